fetch_ibus: RTL and testbench
=============================

# fetch_ibus

Instruction-fetch bus master for the fetch stage of the five-stage MIPS pipeline. It takes the current PC from the F register, issues one SRAM-like instruction-bus transaction per PC, and returns the fetched word to the D register. It produces the `i_data_ok` completion strobe that the hazard unit uses to derive `stallF`. It handles the decode stall, pipeline flush while a transaction is outstanding, and PC address-error detection.

## Interface
Parameters:
- `RESET_PC`, 32'hbfc0_0000: `pc_out` value while in reset.

Ports:
- `clk`  in  1  pipeline clock.
- `resetn`  in  1  synchronous, active-low reset.
- `pc`  in  32  current fetch PC from F register; changes only after a completion with `stall`=0.
- `stall`  in  1  stallD; decode will not accept an instruction this cycle.
- `flush`  in  1  redirect (exception/eret); the in-flight or held instruction is dead.
- `inst_req`  out  1  bus request.
- `inst_addr`  out  32  bus address, word aligned.
- `inst_addr_ok`  in  1  address accepted this cycle.
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  32  read data.
- `i_data_ok`  out  1  instruction valid to D register/hazard unit.
- `instr`  out  32  fetched instruction.
- `pc_out`  out  32  PC of `instr`.
- `pcplus4`  out  32  `pc + 4`, combinational, to PC select (`pcplus4F`).
- `exc_adel`  out  1  instruction-fetch address error for `pc_out`.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DROP. A single-bit `drop_pending` flag is kept alongside the state.
- IDLE: entered only from reset. Advances to REQ on the next cycle.
- REQ:
  - `inst_req`=1, `inst_addr`={pc[31:2],2'b00}.
  - `inst_addr`, and therefore `pc`, must be stable until `inst_addr_ok`.
  - On `inst_addr_ok`: go to WAIT, or to DROP if `flush`, or `drop_pending` is set.
  - `flush` without `inst_addr_ok`: set `drop_pending`. The request stays asserted because the bus forbids withdrawal.
- WAIT:
  - `inst_req`=0.
  - On `inst_data_ok` with neither `flush` nor `stall`: `i_data_ok`=1 and `instr`=`inst_rdata` the same cycle (bypass). `pc_out`=`pc`. Go to REQ.
  - On `inst_data_ok` with `stall` and no `flush`: capture the word into the hold register, go to HOLD. `i_data_ok`=1 is still asserted that cycle.
  - `flush` with or before `inst_data_ok`: the data is discarded and `i_data_ok` stays 0. If `inst_data_ok` arrives in the same cycle, go to REQ; otherwise go to DROP.
- HOLD:
  - `i_data_ok`=1 and `instr`=hold register.
  - Leave for REQ when `stall`=0 or `flush`=1.
- DROP: wait for `inst_data_ok`, discard it, clear `drop_pending`, go to REQ.
- At most one outstanding transaction; no speculative prefetch.
- `flush` outranks `stall` in every state.
- Reset mid-transaction: the bus response that follows the reset is ignored, because the block is in IDLE, which does not watch `inst_data_ok`. The system resets the bus slave together with this block.

## Timing
- Reset values: `inst_req`=0, `inst_addr`=0, `i_data_ok`=0, `instr`=0, `pc_out`=`RESET_PC`, `exc_adel`=0, `drop_pending`=0, state=IDLE.
- Latency: REQ cycle → `inst_addr_ok` → `inst_data_ok` at the earliest one cycle later → `i_data_ok` in that same cycle.
- Best-case throughput is one instruction per 2 cycles: REQ with `addr_ok`, then WAIT with `data_ok`.
- Back-to-back transactions: the REQ state following a completion presents the new `pc` in the next cycle.
- `inst_addr_ok` and `inst_data_ok` are never asserted in the same cycle for the same transaction. The block treats `inst_data_ok` seen in REQ as a slave protocol error and ignores it.

## Configuration
- `FETCH_ADEL_CHECK_EN` defined:
  - In REQ with pc[1:0]≠0: no bus request.
  - `i_data_ok`=1, `instr`=32'h0 (nop), `exc_adel`=1, `pc_out`=`pc`.
  - Stays in REQ, holding while `stall`, until `flush` redirects.
- Not defined: `exc_adel` is tied 0, the low PC bits are ignored, and the aligned address is always requested.

## Test plan
- Reset release with `pc`=bfc00000, slave `addr_ok` in 1st REQ cycle and `data_ok` next cycle, rdata 24020001 → `i_data_ok`=1 with `instr`=24020001 in cycle 2. `inst_req` is high in the next cycle with the new `pc` bfc00004.
- `data_ok` (rdata 3c011234) while `stall`=1 for 3 cycles → `i_data_ok`=1 and `instr`=3c011234 held across all 3 cycles, no new `inst_req` until `stall` falls.
- `flush` in the cycle after `addr_ok`, `data_ok` arriving 2 cycles later → `i_data_ok` never rises for that word. The next `inst_req` carries the redirected `pc` (bfc00380).
- `flush` in REQ while `addr_ok`=0 for 2 cycles → `inst_req` and the old `inst_addr` are held until `addr_ok`, the response is dropped, then REQ with the new `pc`.
- `flush` and `stall` both high in the cycle `data_ok` arrives → data dropped, `i_data_ok`=0, REQ next cycle.
- With `FETCH_ADEL_CHECK_EN`, `pc`=bfc00002 → `inst_req`=0, `i_data_ok`=1, `exc_adel`=1, `instr`=0. Without the macro → `inst_addr`=bfc00000 is requested and `exc_adel`=0.

Source files
------------

// File: rtl/fetch_ibus_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ibus_if
// Description : SRAM-like instruction-bus bundle between the fetch-stage bus
//               master (fetch_ibus) and the instruction memory slave.
// Signals     : inst_req     master->slave  request strobe
//               inst_addr    master->slave  word-aligned fetch address
//               inst_addr_ok slave->master  address accepted this cycle
//               inst_data_ok slave->master  read data valid this cycle
//               inst_rdata   slave->master  read data
// Revision    : 1.0  initial release
// ============================================================================
interface fetch_ibus_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ibus.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ibus
// Description : Instruction-fetch bus master for the five-stage MIPS pipeline.
//               Issues one instruction-bus transaction per PC, returns the
//               word to the D register with the i_data_ok strobe, and copes
//               with decode stall, flush with a transaction in flight and
//               (optionally) PC address errors.
// Macro       : FETCH_ADEL_CHECK_EN - when defined, a misaligned PC raises
//               exc_adel with a nop instead of issuing a bus request.
// Parameters  : RESET_PC  value of pc_out while in reset
// Ports       : clk, resetn (sync, active low)
//               pc, stall, flush        pipeline control inputs
//               bus                     instruction bus (master modport)
//               i_data_ok, instr,       instruction handed to decode
//               pc_out, exc_adel
//               pcplus4                 pc + 4 (combinational)
// Revision    : 1.0  initial release
// ============================================================================
module fetch_ibus #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    input  wire logic [31:0] pc,
    input  wire logic        stall,
    input  wire logic        flush,
    fetch_ibus_if.master     bus,
    output logic             i_data_ok,
    output logic [31:0]      instr,
    output logic [31:0]      pc_out,
    output logic [31:0]      pcplus4,
    output logic             exc_adel
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_drop_pending;
    logic [31:0] r_held_addr;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;

    logic [31:0] w_aligned;
    logic        w_adel;

    assign w_aligned = {pc[31:2], 2'b00};
    assign pcplus4   = pc + 32'd4;

    // A request already on the bus for a killed PC must run to completion,
    // so the alignment check only applies while no such request is pending.
`ifdef FETCH_ADEL_CHECK_EN
    assign w_adel = (pc[1:0] != 2'b00) && !r_drop_pending;
`else
    assign w_adel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_drop_pending <= 1'b0;
            r_held_addr    <= '0;
            r_hold_instr   <= '0;
            r_hold_pc      <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;

                S_REQ: begin
                    // Misaligned PC: no request, sit here until redirected.
                    if (!w_adel) begin
                        if (bus.inst_addr_ok) begin
                            r_state <= (flush || r_drop_pending) ? S_DROP : S_WAIT;
                        end else if (flush && !r_drop_pending) begin
                            // Bus forbids withdrawing the request; keep the
                            // old address on the bus while pc redirects.
                            r_drop_pending <= 1'b1;
                            r_held_addr    <= w_aligned;
                        end
                    end
                end

                S_WAIT: begin
                    if (flush) begin
                        r_state <= bus.inst_data_ok ? S_REQ : S_DROP;
                    end else if (bus.inst_data_ok) begin
                        if (stall) begin
                            r_hold_instr <= bus.inst_rdata;
                            r_hold_pc    <= pc;
                            r_state      <= S_HOLD;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end

                S_HOLD: begin
                    if (flush || !stall) begin
                        r_state <= S_REQ;
                    end
                end

                S_DROP: begin
                    if (bus.inst_data_ok) begin
                        r_drop_pending <= 1'b0;
                        r_state        <= S_REQ;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from state and live bus inputs so read data can be
    // bypassed to decode in the same cycle inst_data_ok arrives.
    always_comb begin
        bus.inst_req  = 1'b0;
        bus.inst_addr = '0;
        i_data_ok     = 1'b0;
        instr         = '0;
        pc_out        = RESET_PC;
        exc_adel      = 1'b0;
        if (resetn) begin
            case (r_state)
                S_REQ: begin
                    pc_out = pc;
                    if (w_adel) begin
                        i_data_ok = !flush;
                        exc_adel  = !flush;
                    end else begin
                        bus.inst_req  = 1'b1;
                        bus.inst_addr = r_drop_pending ? r_held_addr : w_aligned;
                    end
                end
                S_WAIT: begin
                    pc_out = pc;
                    if (bus.inst_data_ok && !flush) begin
                        i_data_ok = 1'b1;
                        instr     = bus.inst_rdata;
                    end
                end
                S_HOLD: begin
                    pc_out = r_hold_pc;
                    if (!flush) begin
                        i_data_ok = 1'b1;
                        instr     = r_hold_instr;
                    end
                end
                S_DROP: pc_out = pc;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ibus.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ibus
// Description : Directed testbench for fetch_ibus. Stimulus pushes expected
//               instructions into a queue; a monitor compares every cycle in
//               which the DUT presents i_data_ok.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_ibus;
    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        i_data_ok;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pcplus4;
    logic        exc_adel;

    fetch_ibus_if bus ();

    fetch_ibus #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pc        (pc),
        .stall     (stall),
        .flush     (flush),
        .bus       (bus),
        .i_data_ok (i_data_ok),
        .instr     (instr),
        .pc_out    (pc_out),
        .pcplus4   (pcplus4),
        .exc_adel  (exc_adel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input logic [31:0] i, input logic [31:0] p, input logic a);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        e.adel  = a;
        exp_q.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: front entry compared on every i_data_ok cycle,
    // retired only when decode accepts it (no stall).
    always @(negedge clk) begin
        if (resetn === 1'b1 && i_data_ok === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_i_data_ok: got instr %h pc_out %h, expected no instruction",
                         instr, pc_out);
            end else begin
                exp_t e;
                e = exp_q[0];
                check("mon_instr", instr, e.instr);
                check("mon_pc_out", pc_out, e.pc);
                check("mon_exc_adel", {31'b0, exc_adel}, {31'b0, e.adel});
                if (!stall) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; pc = 32'hbfc0_0000; stall = 1'b0; flush = 1'b0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
        next(); next();
        check("rst_inst_req", {31'b0, bus.inst_req}, 32'd0);
        check("rst_inst_addr", bus.inst_addr, 32'd0);
        check("rst_i_data_ok", {31'b0, i_data_ok}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc_out", pc_out, RESET_PC);
        check("rst_exc_adel", {31'b0, exc_adel}, 32'd0);

        // Reset release, best-case fetch
        next(); resetn = 1'b1; #1;
        check("idle_no_req", {31'b0, bus.inst_req}, 32'd0);
        next(); bus.inst_addr_ok = 1'b1; #1;
        check("t1_req", {31'b0, bus.inst_req}, 32'd1);
        check("t1_addr", bus.inst_addr, 32'hbfc0_0000);
        next(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h2402_0001;
        expect_instr(32'h2402_0001, 32'hbfc0_0000, 1'b0); #1;
        check("t1_i_data_ok", {31'b0, i_data_ok}, 32'd1);
        next(); bus.inst_data_ok = 1'b0; pc = 32'hbfc0_0004; bus.inst_addr_ok = 1'b1; #1;
        check("t1_next_req", {31'b0, bus.inst_req}, 32'd1);
        check("t1_next_addr", bus.inst_addr, 32'hbfc0_0004);

        // Decode stall for 3 cycles while the word is delivered
        next(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h3c01_1234; stall = 1'b1;
        expect_instr(32'h3c01_1234, 32'hbfc0_0004, 1'b0); #1;
        for (int k = 0; k < 2; k++) begin
            next(); bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'hdead_beef; #1;
            check("t2_hold_no_req", {31'b0, bus.inst_req}, 32'd0);
            check("t2_hold_valid", {31'b0, i_data_ok}, 32'd1);
        end
        next(); stall = 1'b0; #1;
        check("t2_release_no_req", {31'b0, bus.inst_req}, 32'd0);
        next(); pc = 32'hbfc0_0008; bus.inst_addr_ok = 1'b1; #1;
        check("t2_next_addr", bus.inst_addr, 32'hbfc0_0008);

        // Flush in WAIT, data 2 cycles later
        next(); bus.inst_addr_ok = 1'b0; flush = 1'b1; pc = 32'hbfc0_0380; #1;
        check("t3_flush_no_valid", {31'b0, i_data_ok}, 32'd0);
        next(); flush = 1'b0; #1;
        check("t3_drop_no_req", {31'b0, bus.inst_req}, 32'd0);
        next(); bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h1111_1111; #1;
        check("t3_drop_no_valid", {31'b0, i_data_ok}, 32'd0);

        // Flush in REQ without addr_ok for 2 cycles
        next(); bus.inst_data_ok = 1'b0; flush = 1'b1; #1;
        check("t3_redirect_req", {31'b0, bus.inst_req}, 32'd1);
        check("t3_redirect_addr", bus.inst_addr, 32'hbfc0_0380);
        next(); pc = 32'hbfc0_0100; #1;
        check("t4_held_req", {31'b0, bus.inst_req}, 32'd1);
        check("t4_held_addr", bus.inst_addr, 32'hbfc0_0380);
        next(); flush = 1'b0; bus.inst_addr_ok = 1'b1; #1;
        check("t4_held_addr2", bus.inst_addr, 32'hbfc0_0380);
        next(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h2222_2222; #1;
        check("t4_drop_no_valid", {31'b0, i_data_ok}, 32'd0);
        next(); bus.inst_data_ok = 1'b0; bus.inst_addr_ok = 1'b1; #1;
        check("t4_new_req", {31'b0, bus.inst_req}, 32'd1);
        check("t4_new_addr", bus.inst_addr, 32'hbfc0_0100);

        // Flush and stall together with data_ok
        next(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h3333_3333;
        stall = 1'b1; flush = 1'b1; pc = 32'hbfc0_0200; #1;
        check("t5_no_valid", {31'b0, i_data_ok}, 32'd0);
        next(); bus.inst_data_ok = 1'b0; stall = 1'b0; flush = 1'b0; bus.inst_addr_ok = 1'b1; #1;
        check("t5_req", {31'b0, bus.inst_req}, 32'd1);
        check("t5_addr", bus.inst_addr, 32'hbfc0_0200);
        next(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h8c43_0000;
        expect_instr(32'h8c43_0000, 32'hbfc0_0200, 1'b0); #1;
        check("t5_valid", {31'b0, i_data_ok}, 32'd1);

        // Misaligned PC
        next(); bus.inst_data_ok = 1'b0; pc = 32'hbfc0_0002;
`ifdef FETCH_ADEL_CHECK_EN
        expect_instr(32'h0, 32'hbfc0_0002, 1'b1); #1;
        check("t6_pcplus4", pcplus4, 32'hbfc0_0006);
        check("t6_no_req", {31'b0, bus.inst_req}, 32'd0);
        check("t6_adel", {31'b0, exc_adel}, 32'd1);
        check("t6_valid", {31'b0, i_data_ok}, 32'd1);
        next(); flush = 1'b1; #1;
        check("t6_flush_no_valid", {31'b0, i_data_ok}, 32'd0);
        next(); flush = 1'b0; pc = 32'hbfc0_0300; #1;
        check("t6_redirect_req", {31'b0, bus.inst_req}, 32'd1);
        check("t6_redirect_addr", bus.inst_addr, 32'hbfc0_0300);
`else
        bus.inst_addr_ok = 1'b1; #1;
        check("t6_pcplus4", pcplus4, 32'hbfc0_0006);
        check("t6_req", {31'b0, bus.inst_req}, 32'd1);
        check("t6_addr", bus.inst_addr, 32'hbfc0_0000);
        check("t6_no_adel", {31'b0, exc_adel}, 32'd0);
        next(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h0123_4567;
        expect_instr(32'h0123_4567, 32'hbfc0_0002, 1'b0); #1;
        next(); bus.inst_data_ok = 1'b0; pc = 32'hbfc0_0004; #1;
        check("t6_next_addr", bus.inst_addr, 32'hbfc0_0004);
`endif

        next(); next(); next();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
